// File: rtl/nco_sweep_if.sv
// Control and observation bundle for the sweeping NCO.
interface nco_sweep_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 12
);
    logic             en;
    logic             phase_sync;
    logic [ACC_W-1:0] ftw_in;
    logic             ftw_load;
    logic [ACC_W-1:0] pow_in;
    logic             pow_load;
    logic             sweep_en;
    logic [ACC_W-1:0] sweep_step;
    logic [ACC_W-1:0] sweep_stop;
    logic [OUT_W-1:0] phase_out;
    logic             clkout;
    logic             acc_wrap;
    logic             sweep_wrap;
    logic [ACC_W-1:0] ftw_cur_o;

    modport master (
        output en, phase_sync, ftw_in, ftw_load, pow_in, pow_load,
               sweep_en, sweep_step, sweep_stop,
        input  phase_out, clkout, acc_wrap, sweep_wrap, ftw_cur_o
    );

    modport slave (
        input  en, phase_sync, ftw_in, ftw_load, pow_in, pow_load,
               sweep_en, sweep_step, sweep_stop,
        output phase_out, clkout, acc_wrap, sweep_wrap, ftw_cur_o
    );
endinterface

// File: rtl/nco_sweep.sv
// Phase-accumulator NCO with tuning/offset load, phase sync and linear chirp.
module nco_sweep #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    nco_sweep_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_cur_q, ftw_cur_d;
    logic [ACC_W-1:0] ftw_start_q, ftw_start_d;
    logic [ACC_W-1:0] pow_cur_q, pow_cur_d;
    logic [OUT_W-1:0] phase_q, phase_d;
    logic             acc_wrap_q, acc_wrap_d;
    logic             sweep_wrap_q, sweep_wrap_d;

    logic             accumulate;
    logic             sweep_begin;
    logic             sweep_advance;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W:0]   ftw_next;
    logic [ACC_W-1:0] phase_sum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: en gates everything, sweep_en picks the running mode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN, SWEEP: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (bus.sweep_en) begin
                    state_d = SWEEP;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the destination state decides this edge's datapath action
    always_comb begin
        accumulate    = (state_d != IDLE);
        sweep_begin   = (state_q == RUN) && (state_d == SWEEP);
        sweep_advance = (state_q == SWEEP) && (state_d == SWEEP);
    end

    // Datapath next-state: accumulate, chirp step/restart, load strobes, output pipe
    always_comb begin
        acc_sum      = {1'b0, acc_q} + {1'b0, ftw_cur_q};
        ftw_next     = {1'b0, ftw_cur_q} + {1'b0, bus.sweep_step};
        phase_sum    = acc_q + pow_cur_q;
        phase_d      = OUT_W'(phase_sum >> (ACC_W - OUT_W));

        acc_d        = acc_q;
        acc_wrap_d   = 1'b0;
        ftw_cur_d    = ftw_cur_q;
        ftw_start_d  = ftw_start_q;
        pow_cur_d    = pow_cur_q;
        sweep_wrap_d = 1'b0;

        if (bus.phase_sync) begin
            acc_d = '0;
        end else if (accumulate) begin
            acc_d      = acc_sum[ACC_W-1:0];
            acc_wrap_d = acc_sum[ACC_W];
        end

        if (sweep_begin) begin
            ftw_cur_d = ftw_start_q;
        end else if (sweep_advance) begin
            if (ftw_next > {1'b0, bus.sweep_stop}) begin
                ftw_cur_d    = ftw_start_q;
                sweep_wrap_d = 1'b1;
            end else begin
                ftw_cur_d = ftw_next[ACC_W-1:0];
            end
        end

        // A tuning-word load wins over any sweep action on the same edge
        if (bus.ftw_load) begin
            ftw_cur_d    = bus.ftw_in;
            ftw_start_d  = bus.ftw_in;
            sweep_wrap_d = 1'b0;
        end

        if (bus.pow_load) begin
            pow_cur_d = bus.pow_in;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            ftw_cur_q    <= '0;
            ftw_start_q  <= '0;
            pow_cur_q    <= '0;
            phase_q      <= '0;
            acc_wrap_q   <= 1'b0;
            sweep_wrap_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ftw_cur_q    <= ftw_cur_d;
            ftw_start_q  <= ftw_start_d;
            pow_cur_q    <= pow_cur_d;
            phase_q      <= phase_d;
            acc_wrap_q   <= acc_wrap_d;
            sweep_wrap_q <= sweep_wrap_d;
        end
    end

    assign bus.phase_out  = phase_q;
    assign bus.clkout     = phase_q[OUT_W-1];
    assign bus.acc_wrap   = acc_wrap_q;
    assign bus.sweep_wrap = sweep_wrap_q;
    assign bus.ftw_cur_o  = ftw_cur_q;
endmodule
